// File: rtl/seg_shift_ctrl_pkg.sv
// Shared definitions for the serial 7-segment shift-out controller:
// state encoding, digit byte width and counter sizing helper.
package seg_shift_ctrl_pkg;

    localparam int SEG_W       = 8;
    localparam int CLK_DIV_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT_LO = 2'd1,
        ST_SHIFT_HI = 2'd2,
        ST_LATCH    = 2'd3
    } seg_state_t;

    // Counter width for a modulus n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_shift_ctrl_if.sv
// Request/status and display-pin bundle of the segment shift-out controller.
// master = requester side, slave = controller side.
interface seg_shift_ctrl_if #(
    parameter int NDIG = 8
);
    import seg_shift_ctrl_pkg::*;

    logic [SEG_W*NDIG-1:0] segnum_in;
    logic                  load;
    logic                  busy;
    logic                  done;
    logic                  seg_clk;
    logic                  seg_dat;
    logic                  seg_le;

    modport master (
        output segnum_in, load,
        input  busy, done, seg_clk, seg_dat, seg_le
    );

    modport slave (
        input  segnum_in, load,
        output busy, done, seg_clk, seg_dat, seg_le
    );

endinterface

// File: rtl/seg_shift_ctrl_phase_tick.sv
// Phase timer for the shift controller: counts 0..CLK_DIV-1 and flags the
// last cycle of each seg_clk half-period with a 1-cycle phase_end.
module seg_phase_tick
    import seg_shift_ctrl_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic phase_end
);
    localparam int CW = cnt_w(CLK_DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr || phase_end)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign phase_end = (cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/seg_shift_ctrl.sv
// Serial shift-out controller for the shift-register 7-segment display.
// Optional build macro SEG_AUTO_REFRESH_EN adds a periodic self-refresh request.
//   state       | meaning
//   ST_IDLE     | waiting for load / pending / refresh request
//   ST_SHIFT_LO | seg_clk low, current MSB on seg_dat
//   ST_SHIFT_HI | seg_clk high, display samples the bit
//   ST_LATCH    | seg_le high, word transferred to the outputs
module seg_shift_ctrl
    import seg_shift_ctrl_pkg::*;
#(
    parameter int NDIG        = 8,
    parameter int CLK_DIV     = CLK_DIV_DEF,
    parameter int REFRESH_CYC = 1_000_000
) (
    input logic             clk,
    input logic             rst,
    seg_shift_ctrl_if.slave bus
);
    localparam int NB = SEG_W * NDIG;
    localparam int BW = cnt_w(NB);

    if (CLK_DIV < 1 || REFRESH_CYC < 2) begin : g_bad_param
        $error("seg_shift_ctrl: CLK_DIV must be >= 1 and REFRESH_CYC >= 2");
    end

    seg_state_t    state, state_nxt;
    logic [NB-1:0] shreg, shreg_nxt;
    logic [NB-1:0] shadow, shadow_nxt;
    logic [BW-1:0] bit_cnt, bit_cnt_nxt;
    logic          pending, pending_nxt;
    logic          done_nxt;
    logic          req;
    logic          start;
    logic          last_bit;
    logic          phase_end;

`ifdef SEG_AUTO_REFRESH_EN
    localparam int RW = cnt_w(REFRESH_CYC);
    logic [RW-1:0] ref_cnt;
    logic          ref_wrap;

    assign ref_wrap = (ref_cnt == RW'(REFRESH_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst || ref_wrap)
            ref_cnt <= '0;
        else
            ref_cnt <= ref_cnt + RW'(1);
    end

    // A refresh behaves exactly like an external load of the live word.
    assign req = bus.load | ref_wrap;
`else
    assign req = bus.load;
`endif

    assign start    = (state == ST_IDLE) && (req || pending);
    assign last_bit = (bit_cnt == BW'(NB - 1));

    seg_phase_tick #(.CLK_DIV(CLK_DIV)) u_phase (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == ST_IDLE),
        .phase_end (phase_end)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        pending_nxt = pending;
        shadow_nxt  = shadow;
        done_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt   = ST_SHIFT_LO;
                    shreg_nxt   = req ? bus.segnum_in : shadow;
                    bit_cnt_nxt = '0;
                    pending_nxt = 1'b0;
                end
            end
            ST_SHIFT_LO: begin
                if (phase_end)
                    state_nxt = ST_SHIFT_HI;
            end
            ST_SHIFT_HI: begin
                if (phase_end) begin
                    shreg_nxt   = {shreg[NB-2:0], 1'b0};
                    bit_cnt_nxt = bit_cnt + BW'(1);
                    state_nxt   = last_bit ? ST_LATCH : ST_SHIFT_LO;
                end
            end
            ST_LATCH: begin
                if (phase_end) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Requests arriving mid-sequence are queued; the latest word wins.
        if (state != ST_IDLE && req) begin
            pending_nxt = 1'b1;
            shadow_nxt  = bus.segnum_in;
        end
    end

    // Pins are registered from the next state so seg_clk/seg_le never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg       <= '0;
            shadow      <= '0;
            bit_cnt     <= '0;
            pending     <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.seg_clk <= 1'b0;
            bus.seg_dat <= 1'b0;
            bus.seg_le  <= 1'b0;
        end else begin
            shreg       <= shreg_nxt;
            shadow      <= shadow_nxt;
            bit_cnt     <= bit_cnt_nxt;
            pending     <= pending_nxt;
            bus.busy    <= (state_nxt != ST_IDLE);
            bus.done    <= done_nxt;
            bus.seg_clk <= (state_nxt == ST_SHIFT_HI);
            bus.seg_dat <= ((state_nxt == ST_SHIFT_LO) || (state_nxt == ST_SHIFT_HI)) && shreg_nxt[NB-1];
            bus.seg_le  <= (state_nxt == ST_LATCH);
        end
    end

endmodule

// File: tb/tb_seg_shift_ctrl.sv
// Bench for seg_shift_ctrl: a CLK_DIV=2 and a CLK_DIV=1 instance, each checked every
// cycle against a timeline model of the shift/latch sequence (refresh mirrored under SEG_AUTO_REFRESH_EN).
`timescale 1ns/1ps
module tb_seg_shift_ctrl;
    localparam int NDIG = 2;
    localparam int NB   = 8 * NDIG;
    localparam int REF  = 200;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_shift_ctrl_if #(.NDIG(NDIG)) bus_a ();
    seg_shift_ctrl_if #(.NDIG(NDIG)) bus_b ();

    seg_shift_ctrl #(.NDIG(NDIG), .CLK_DIV(2), .REFRESH_CYC(REF)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    seg_shift_ctrl #(.NDIG(NDIG), .CLK_DIV(1), .REFRESH_CYC(REF)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a sequence accepted at edge s shows, after edge s+k, the output for offset k.
    int            edge_n   = 0;
    int            rst_edge = 0;
    bit            started  = 1'b0;
    bit            act  [2];
    int            st   [2];
    logic [NB-1:0] wd   [2];
    bit            pend [2];
    logic [NB-1:0] shad [2];
    logic [4:0]    exp_o [2];

    // Monitor state: word rebuilt from seg_dat at seg_clk rises, seg_le length.
    logic [NB-1:0] cap   [2];
    int            lecnt [2];
    logic          pclk  [2];
    int            seen_rst = 0;
    logic [NB-1:0] words_a [$];
    logic [NB-1:0] words_b [$];
    int            le_a [$];
    int            le_b [$];

    function automatic int cdiv(input int id);
        return (id == 0) ? 2 : 1;
    endfunction

    // Edges from accept to the done cycle: shift phase plus latch phase.
    function automatic int seq_len(input int id);
        return 2 * cdiv(id) * NB + cdiv(id);
    endfunction

    // {busy, done, seg_clk, seg_dat, seg_le} at offset k of a sequence.
    function automatic logic [4:0] predict(input int id, input int k);
        int   cd;
        int   sh;
        logic hi;
        cd = cdiv(id);
        sh = 2 * cd * NB;
        if (k < sh) begin
            hi = ((k % (2 * cd)) >= cd);
            return {1'b1, 1'b0, hi, wd[id][NB - 1 - k / (2 * cd)], 1'b0};
        end
        if (k < sh + cd) return 5'b10001;
        if (k == sh + cd) return 5'b01000;
        return 5'b00000;
    endfunction

    always @(posedge clk) begin
        logic          ld;
        logic [NB-1:0] din;
        logic          req;
        logic          idle;
        edge_n = edge_n + 1;
        if (rst) begin
            started  = 1'b1;
            rst_edge = edge_n;
        end
        for (int id = 0; id < 2; id++) begin
            ld  = (id == 0) ? bus_a.load : bus_b.load;
            din = (id == 0) ? bus_a.segnum_in : bus_b.segnum_in;
            if (rst) begin
                act[id]   = 1'b0;
                pend[id]  = 1'b0;
                shad[id]  = '0;
                exp_o[id] = '0;
            end else begin
                req = ld;
`ifdef SEG_AUTO_REFRESH_EN
                if (edge_n > rst_edge && ((edge_n - rst_edge) % REF) == 0)
                    req = 1'b1;
`endif
                idle = !act[id] || ((edge_n - 1 - st[id]) >= seq_len(id));
                if (idle && (req || pend[id])) begin
                    wd[id]   = req ? din : shad[id];
                    st[id]   = edge_n;
                    act[id]  = 1'b1;
                    pend[id] = 1'b0;
                end else if (!idle && req) begin
                    pend[id] = 1'b1;
                    shad[id] = din;
                end
                exp_o[id] = act[id] ? predict(id, edge_n - st[id]) : 5'b00000;
            end
        end
    end

    task automatic monitor();
        logic [4:0] o;
        forever begin
            @(negedge clk);
            if (started) begin
                if (seen_rst != rst_edge) begin
                    seen_rst = rst_edge;
                    for (int j = 0; j < 2; j++) begin
                        cap[j]   = '0;
                        lecnt[j] = 0;
                        pclk[j]  = 1'b0;
                    end
                end
                for (int id = 0; id < 2; id++) begin
                    o = (id == 0) ? {bus_a.busy, bus_a.done, bus_a.seg_clk, bus_a.seg_dat, bus_a.seg_le}
                                  : {bus_b.busy, bus_b.done, bus_b.seg_clk, bus_b.seg_dat, bus_b.seg_le};
                    n_cmp++;
                    if (o !== exp_o[id]) begin
                        n_bad++;
                        $display("FAIL outputs dut%0d edge %0d: got busy/done/clk/dat/le=%b required %b",
                                 id, edge_n, o, exp_o[id]);
                    end
                    if (!pclk[id] && o[2]) cap[id] = {cap[id][NB-2:0], o[1]};
                    if (o[0]) lecnt[id]++;
                    if (o[3]) begin
                        if (id == 0) begin
                            words_a.push_back(cap[id]);
                            le_a.push_back(lecnt[id]);
                        end else begin
                            words_b.push_back(cap[id]);
                            le_b.push_back(lecnt[id]);
                        end
                        cap[id]   = '0;
                        lecnt[id] = 0;
                    end
                    pclk[id] = o[2];
                end
            end
        end
    endtask

    task automatic chk(input string nm, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int id, input logic [NB-1:0] w, output int acc_edge);
        if (id == 0) begin
            bus_a.load = 1'b1; bus_a.segnum_in = w;
        end else begin
            bus_b.load = 1'b1; bus_b.segnum_in = w;
        end
        acc_edge = edge_n + 1;
        @(negedge clk);
        if (id == 0) bus_a.load = 1'b0;
        else         bus_b.load = 1'b0;
    endtask

    task automatic wait_done(input int id, input int budget, output int e_out);
        e_out = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((id == 0) ? bus_a.done : bus_b.done) begin
                e_out = edge_n;
                break;
            end
        end
        n_cmp++;
        if (e_out < 0) begin
            n_bad++;
            $display("FAIL timeout_done dut%0d: got no done within %0d cycles required done", id, budget);
        end
    endtask

    task automatic chk_word(input int id, input string nm, input logic [NB-1:0] want);
        logic [NB-1:0] w;
        int            le;
        if (((id == 0) ? words_a.size() : words_b.size()) == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got no completed sequence required 0x%0h", nm, want);
        end else begin
            if (id == 0) begin
                w = words_a.pop_front(); le = le_a.pop_front();
            end else begin
                w = words_b.pop_front(); le = le_b.pop_front();
            end
            chk(nm, w, want);
            chk({nm, "_le_len"}, le, cdiv(id));
        end
    endtask

    initial begin
        int e0, e1, d1, d2;
        rst             = 1'b1;
        bus_a.load      = 1'b0;
        bus_a.segnum_in = '0;
        bus_b.load      = 1'b0;
        bus_b.segnum_in = '0;
        fork
            monitor();
        join_none
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("reset_a", {bus_a.busy, bus_a.done, bus_a.seg_clk, bus_a.seg_dat, bus_a.seg_le}, 0);
        chk("reset_b", {bus_b.busy, bus_b.done, bus_b.seg_clk, bus_b.seg_dat, bus_b.seg_le}, 0);

`ifndef SEG_AUTO_REFRESH_EN
        // Basic shift, CLK_DIV=2: done 67 cycles after the load edge.
        pulse(0, 16'hA5C3, e0);
        wait_done(0, 200, d1);
        if (d1 >= 0) chk("latency_a", d1 - e0 + 1, 67);
        tick(1);
        chk("busy_after_a", bus_a.busy, 0);
        tick(1);
        chk_word(0, "word_basic", 16'hA5C3);

        // Loads while busy: only the latest queued word runs, right after done.
        pulse(0, 16'h00FF, e0);
        tick(10);
        pulse(0, 16'h1234, e1);
        tick(20);
        pulse(0, 16'hBEEF, e1);
        wait_done(0, 200, d1);
        wait_done(0, 200, d2);
        if (d1 >= 0 && d2 >= 0) chk("gap_pending", d2 - d1, 67);
        tick(100);
        chk("seq_count_pending", words_a.size(), 2);
        chk_word(0, "word_pend_first", 16'h00FF);
        chk_word(0, "word_pend_second", 16'hBEEF);
        words_a.delete();
        le_a.delete();

        // Reset during bit 7 aborts without latching.
        pulse(0, 16'hC3A5, e0);
        tick(28);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("abort_outputs", {bus_a.busy, bus_a.done, bus_a.seg_clk, bus_a.seg_dat, bus_a.seg_le}, 0);
        tick(80);
        chk("abort_no_done", words_a.size(), 0);
        pulse(0, 16'h5A3C, e0);
        wait_done(0, 200, d1);
        tick(2);
        chk_word(0, "word_after_rst", 16'h5A3C);

        // Load in the done cycle: busy low for exactly one cycle.
        pulse(0, 16'h1111, e0);
        wait_done(0, 200, d1);
        bus_a.load      = 1'b1;
        bus_a.segnum_in = 16'h2222;
        chk("busy_done_cycle", bus_a.busy, 0);
        tick(1);
        bus_a.load = 1'b0;
        chk("busy_restart", bus_a.busy, 1);
        wait_done(0, 200, d2);
        tick(2);
        chk_word(0, "word_done_first", 16'h1111);
        chk_word(0, "word_done_second", 16'h2222);

        // CLK_DIV=1 boundary.
        pulse(1, 16'h8001, e0);
        wait_done(1, 100, d1);
        if (d1 >= 0) chk("latency_b", d1 - e0 + 1, 34);
        tick(2);
        chk_word(1, "word_div1", 16'h8001);
`endif

        // Random loads, live word changes and occasional resets.
        for (int c = 0; c < 2000; c++) begin
            bus_a.load      = ($urandom_range(0, 15) == 0);
            bus_a.segnum_in = 16'($urandom);
            bus_b.load      = ($urandom_range(0, 11) == 0);
            bus_b.segnum_in = 16'($urandom);
            rst             = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        bus_a.load      = 1'b0;
        bus_b.load      = 1'b0;
        rst             = 1'b0;
        bus_a.segnum_in = 16'h3C5A;
        bus_b.segnum_in = 16'h0F0F;
        tick(150);
        words_a.delete();
        words_b.delete();
        le_a.delete();
        le_b.delete();
        tick(500);
`ifdef SEG_AUTO_REFRESH_EN
        if (words_a.size() < 2) begin
            n_cmp++;
            n_bad++;
            $display("FAIL refresh_count: got %0d sequences required at least 2", words_a.size());
        end else begin
            chk("refresh_word", words_a[words_a.size() - 1], 16'h3C5A);
        end
`else
        chk("no_auto_start_a", words_a.size(), 0);
        chk("no_auto_start_b", words_b.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
